// File: rtl/img_gray_frame_walker.sv
// Frame sequencer: streams every RGB pixel of a frame through the grayscale converter
// and writes the result back at the same address. Optional `FRAME_CHECKSUM_EN adds checksum.
module img_gray_frame_walker #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [11:0]       src_rdata,
    output logic [11:0]       conv_in,
    input  logic [11:0]       conv_out,
    output logic              dst_wr_en,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [11:0]       dst_wdata,
    input  logic              dst_ready
`ifdef FRAME_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int              NPIX_I = IMG_W * IMG_H;
    localparam logic [ADDR_W:0] NPIX   = NPIX_I[ADDR_W:0];

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W:0]   rd_cnt;
    logic [ADDR_W:0]   wr_cnt;
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic              skid_vld;
    logic [11:0]       skid_data;
    logic [ADDR_W-1:0] skid_addr;
    logic              stall;
    logic              wr_acc;
    logic              last_wr;
    logic              pix_vld;
    logic [ADDR_W-1:0] pix_addr;

    assign stall    = dst_wr_en & ~dst_ready;
    assign wr_acc   = dst_wr_en & dst_ready;
    assign last_wr  = wr_acc & (wr_cnt == NPIX - 1'b1);
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);

    // A held skid entry blocks new reads so at most one pixel is ever in flight past a stall.
    assign src_rd_en = (state == ST_RUN) & (rd_cnt < NPIX) & ~stall & ~skid_vld;
    assign src_addr  = rd_cnt[ADDR_W-1:0];

    assign pix_vld  = skid_vld | vld_p1;
    assign pix_addr = skid_vld ? skid_addr : addr_p1;
    assign conv_in  = skid_vld ? skid_data : (vld_p1 ? src_rdata : 12'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_RUN;
                        rd_cnt <= '0;
                        wr_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (src_rd_en)
                        rd_cnt <= rd_cnt + 1'b1;
                    if (wr_acc)
                        wr_cnt <= wr_cnt + 1'b1;
                    if (last_wr)
                        state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage 1: read data returning this cycle, or the skid entry parked by a stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            addr_p1   <= '0;
            skid_vld  <= 1'b0;
            skid_data <= '0;
            skid_addr <= '0;
            dst_wr_en <= 1'b0;
            dst_addr  <= '0;
            dst_wdata <= '0;
        end else begin
            vld_p1  <= src_rd_en;
            addr_p1 <= src_addr;
            if (stall) begin
                if (vld_p1) begin
                    skid_vld  <= 1'b1;
                    skid_data <= src_rdata;
                    skid_addr <= addr_p1;
                end
            end else begin
                // Output stage
                skid_vld <= 1'b0;
                if (pix_vld) begin
                    dst_wr_en <= 1'b1;
                    dst_addr  <= pix_addr;
                    dst_wdata <= conv_out;
                end else begin
                    dst_wr_en <= 1'b0;
                end
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            checksum <= '0;
        else if ((state == ST_IDLE) && start)
            checksum <= '0;
        else if (wr_acc)
            checksum <= checksum + {4'd0, dst_wdata};
    end
`endif

endmodule
